// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the local transmit/receive port of the SPI responder
interface spi_slave_if #(parameter int WIDTH = 8);
  logic sck, ss, mosi, miso;
  logic tx_load, tx_ready, rx_valid, underrun, busy;
  logic [WIDTH-1:0] tx_data, rx_data;
  modport master (
    output sck, ss, mosi, tx_data, tx_load,
    input miso, tx_ready, rx_data, rx_valid, underrun, busy
  );
  modport slave (
    input sck, ss, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, underrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder with synchronized pins and a one-deep transmit buffer
module spi_slave #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  spi_slave_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic sck_s, ss_s, mosi_s, sck_d, ss_d;
  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [0:0] state;
  logic active, reload, load_ok, last_bit, word_done, tx_full;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-1:0] tx_buf, tx_sh, rx_sh, shift_in;
  assign sck_s = sck_q[SYNC_STAGES-1];
  assign ss_s = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_rise = ss_s & ~ss_d;
  assign ss_fall = ~ss_s & ss_d;
  assign active = state == ACTIVE;
  assign last_bit = bit_cnt == CW'(WIDTH - 1);
  assign load_ok = bus.tx_load & ~tx_full;
  // A falling SCK at bit 0 is a word boundary inside the frame; SS release wins over it
  assign reload = (~active & ss_fall) | (active & ~ss_rise & sck_fall & bit_cnt == '0);
  assign word_done = active & ~ss_rise & sck_rise & last_bit;
  assign shift_in = {rx_sh[WIDTH-2:0], mosi_s};
  assign bus.miso = active & tx_sh[WIDTH-1];
  assign bus.tx_ready = ~tx_full;
  assign bus.busy = active;
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= '0;
      ss_q <= '0;
      mosi_q <= '0;
      sck_d <= 1'b0;
      ss_d <= 1'b0;
      state <= IDLE;
      bit_cnt <= '0;
      tx_full <= 1'b0;
      tx_buf <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], bus.sck};
      ss_q <= {ss_q[SYNC_STAGES-2:0], bus.ss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
      sck_d <= sck_s;
      ss_d <= ss_s;
      bus.rx_valid <= word_done;
      bus.underrun <= reload & ~tx_full;
      // A load coinciding with an empty-buffer reload is kept for the following word
      tx_full <= reload ? load_ok : (tx_full | load_ok);
      if (load_ok) tx_buf <= bus.tx_data;
      if (reload) tx_sh <= tx_full ? tx_buf : '0;
      else if (active & sck_fall) tx_sh <= tx_sh << 1;
      if (~active & ss_fall) begin
        state <= ACTIVE;
        bit_cnt <= '0;
      end else if (active & ss_rise) begin
        state <= IDLE;
        bit_cnt <= '0;
      end else if (active & sck_rise) begin
        rx_sh <= shift_in;
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (word_done) bus.rx_data <= shift_in;
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks of the SPI responder with a bit-banged master at clk/8
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int pulse_err = 0;
  logic rxv_q = 1'b0;
  logic und_q = 1'b0;
  logic [7:0] rx_last = '0;
  logic [7:0] rx_prev = '0;
  spi_slave_if #(.WIDTH(8)) bus ();
  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_prev = rx_last;
      rx_last = bus.rx_data;
    end
    if (bus.underrun === 1'b1) und_cnt++;
    if ((bus.rx_valid === 1'b1 && rxv_q) || (bus.underrun === 1'b1 && und_q)) pulse_err++;
    rxv_q = bus.rx_valid === 1'b1;
    und_q = bus.underrun === 1'b1;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic load(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
  endtask
  task automatic open_frame();
    bus.ss = 1'b0;
    tick(8);
  endtask
  // Sends the top n bits of m; when last is set, SS is released while SCK is still high
  task automatic send_bits(input logic [7:0] m, input int n, input bit last, output logic [7:0] so);
    so = '0;
    for (int k = 0; k < n; k++) begin
      bus.mosi = m[7-k];
      so[7-k] = bus.miso;
      bus.sck = 1'b1;
      tick(4);
      if (last && k == n - 1) begin
        bus.ss = 1'b1;
        tick(4);
      end
      bus.sck = 1'b0;
      tick(4);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_miso"}, 32'(bus.miso), 0);
    chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 1);
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 0);
    chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
    chk({tag, "_underrun"}, 32'(bus.underrun), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask
  initial begin
    logic [7:0] so, so2;
    int rv0, un0;
    bus.sck = 1'b0;
    bus.ss = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    tick(2);
    rst = 1'b0;
    check_reset("rst");
    tick(6);
    load(8'hA5);
    chk("single_tx_ready_after_load", 32'(bus.tx_ready), 0);
    rv0 = rxv_cnt;
    un0 = und_cnt;
    open_frame();
    chk("single_tx_ready_after_ss", 32'(bus.tx_ready), 1);
    chk("single_busy", 32'(bus.busy), 1);
    send_bits(8'h3C, 8, 1, so);
    chk("single_miso", 32'(so), 32'hA5);
    chk("single_rx_data", 32'(bus.rx_data), 32'h3C);
    chk("single_rx_pulses", rxv_cnt - rv0, 1);
    chk("single_no_underrun", und_cnt - un0, 0);
    chk("idle_miso", 32'(bus.miso), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    load(8'h81);
    rv0 = rxv_cnt;
    un0 = und_cnt;
    open_frame();
    load(8'h7E);
    send_bits(8'h12, 8, 0, so);
    send_bits(8'h34, 8, 1, so2);
    chk("two_miso_0", 32'(so), 32'h81);
    chk("two_miso_1", 32'(so2), 32'h7E);
    chk("two_rx_pulses", rxv_cnt - rv0, 2);
    chk("two_rx_0", 32'(rx_prev), 32'h12);
    chk("two_rx_1", 32'(rx_last), 32'h34);
    chk("two_no_underrun", und_cnt - un0, 0);
    rv0 = rxv_cnt;
    un0 = und_cnt;
    open_frame();
    chk("under_pulse_at_ss", und_cnt - un0, 1);
    send_bits(8'hC3, 8, 1, so);
    chk("under_miso", 32'(so), 0);
    chk("under_rx_data", 32'(bus.rx_data), 32'hC3);
    chk("under_single_pulse", und_cnt - un0, 1);
    rv0 = rxv_cnt;
    open_frame();
    send_bits(8'hAA, 5, 1, so);
    chk("abort_no_rx_valid", rxv_cnt - rv0, 0);
    chk("abort_rx_kept", 32'(bus.rx_data), 32'hC3);
    open_frame();
    send_bits(8'hF0, 8, 1, so);
    chk("abort_next_rx", 32'(bus.rx_data), 32'hF0);
    chk("abort_next_pulses", rxv_cnt - rv0, 1);
    load(8'h5A);
    open_frame();
    send_bits(8'h99, 3, 0, so);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("midrst");
    rv0 = rxv_cnt;
    un0 = und_cnt;
    send_bits(8'h33, 5, 0, so);
    chk("midrst_ignored_busy", 32'(bus.busy), 0);
    chk("midrst_ignored_rx", rxv_cnt - rv0, 0);
    chk("midrst_ignored_underrun", und_cnt - un0, 0);
    chk("midrst_ignored_rx_data", 32'(bus.rx_data), 0);
    bus.ss = 1'b1;
    tick(8);
    open_frame();
    send_bits(8'h6D, 8, 1, so);
    chk("midrst_next_rx", 32'(bus.rx_data), 32'h6D);
    chk("midrst_next_pulses", rxv_cnt - rv0, 1);
    load(8'hE7);
    load(8'h18);
    chk("ignored_tx_ready", 32'(bus.tx_ready), 0);
    open_frame();
    send_bits(8'h00, 8, 1, so);
    chk("ignored_miso", 32'(so), 32'hE7);
    chk("pulse_widths", pulse_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
